// File: rtl/ttl_74323_pkg.sv
// Shared definitions for the 74323 universal shift/storage register:
// mode encodings and the bus-drive decode.
package ttl_74323_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    // Number of single-bit control inputs resolved alongside the data bus:
    // MR_bar, S[1:0], OE1_bar, OE2_bar, DS0, DS7.
    localparam int NUM_CTL = 7;

    // The chip never drives the bus while loading from it.
    function automatic logic bus_drive(input logic oe1_bar, input logic oe2_bar,
                                       input mode_e mode);
        return !oe1_bar && !oe2_bar && (mode != MODE_LOAD);
    endfunction

endpackage

// File: rtl/ttl_input_resolve.sv
// Floating-input model: any bit that is not a solid 0 (Z or X) reads as 1,
// matching an unconnected TTL input.
module ttl_input_resolve #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] res
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign res[i] = (raw[i] === 1'b0) ? 1'b0 : 1'b1;
    end

endmodule

// File: rtl/ttl_74323.sv
// 74323 universal shift/storage register with shared bus I/O: hold, shift
// right, shift left and parallel load, synchronous master reset.
module ttl_74323
    import ttl_74323_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic             Clk,
    input  logic             MR_bar,
    input  logic [1:0]       S,
    input  logic             OE1_bar,
    input  logic             OE2_bar,
    input  logic             DS0,
    input  logic             DS7,
    input  logic [WIDTH-1:0] IO_in,
    output logic [WIDTH-1:0] IO_out,
    output logic             IO_oe,
    output logic             Q0,
    output logic             Q7
);

    logic [WIDTH+NUM_CTL-1:0] raw_in;
    logic [WIDTH+NUM_CTL-1:0] res_in;

    logic             res_mr_bar;
    logic [1:0]       res_s;
    logic             res_oe1_bar;
    logic             res_oe2_bar;
    logic             res_ds0;
    logic             res_ds7;
    logic [WIDTH-1:0] res_bus;
    mode_e            mode;

    // Zero-initialised so the outputs are defined before the first reset.
    logic [WIDTH-1:0] q = '0;

    assign raw_in = {MR_bar, S, OE1_bar, OE2_bar, DS0, DS7, IO_in};

    ttl_input_resolve #(.WIDTH(WIDTH + NUM_CTL)) u_resolve (
        .raw (raw_in),
        .res (res_in)
    );

    assign {res_mr_bar, res_s, res_oe1_bar, res_oe2_bar,
            res_ds0, res_ds7, res_bus} = res_in;
    assign mode = mode_e'(res_s);

    // Reset wins over every mode, including load.
    always_ff @(posedge Clk) begin
        if (!res_mr_bar) begin
            q <= '0;
        end else begin
            unique case (mode)
                MODE_HOLD: q <= q;
                MODE_SHR:  q <= {q[WIDTH-2:0], res_ds0};
                MODE_SHL:  q <= {res_ds7, q[WIDTH-1:1]};
                MODE_LOAD: q <= res_bus;
                default:   q <= q;
            endcase
        end
    end

    assign IO_out = q;
    assign IO_oe  = bus_drive(res_oe1_bar, res_oe2_bar, mode);
    assign Q0     = q[0];
    assign Q7     = q[WIDTH-1];

    // Rise/fall delays are board timing, left to back-annotation; the
    // logical outputs are identical for any delay setting.
    if (DELAY_RISE != 0 || DELAY_FALL != 0) begin : g_timing_annotated
    end

endmodule

// File: tb/tb_ttl_74323.sv
// Directed and random checks of ttl_74323 against an arithmetic model of
// the register (shift = multiply/divide by two, reset = zero).
module tb_ttl_74323;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         MR_bar, OE1_bar, OE2_bar, DS0, DS7;
    logic [1:0]   S;
    logic [W-1:0] IO_in;
    logic [W-1:0] IO_out;
    logic         IO_oe, Q0, Q7;

    int n_cmp = 0;
    int n_bad = 0;
    int m     = 0;     // expected register contents as an integer
    logic probe;
    logic fourstate;
    logic zv;          // Z when the simulator is 4-state, else the value Z resolves to

    ttl_74323 #(.WIDTH(W)) dut (
        .Clk(Clk), .MR_bar(MR_bar), .S(S), .OE1_bar(OE1_bar), .OE2_bar(OE2_bar),
        .DS0(DS0), .DS7(DS7), .IO_in(IO_in), .IO_out(IO_out), .IO_oe(IO_oe),
        .Q0(Q0), .Q7(Q7)
    );

    always #5 Clk = ~Clk;

    function automatic int rb(input logic b);
        return (b === 1'b0) ? 0 : 1;
    endfunction

    function automatic int model_next(input int cur);
        int sel, bus;
        sel = rb(S[1]) * 2 + rb(S[0]);
        bus = 0;
        for (int i = 0; i < W; i++) bus += rb(IO_in[i]) << i;
        if (rb(MR_bar) == 0) return 0;
        case (sel)
            1:       return (cur * 2 + rb(DS0)) % (1 << W);
            2:       return cur / 2 + rb(DS7) * (1 << (W - 1));
            3:       return bus;
            default: return cur;
        endcase
    endfunction

    function automatic logic model_oe();
        return rb(OE1_bar) == 0 && rb(OE2_bar) == 0 && !(rb(S[1]) == 1 && rb(S[0]) == 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [W-1:0] e;
        e = W'(m);
        check({tag, ".io_out"}, 32'(IO_out), 32'(e));
        check({tag, ".q0"}, 32'(Q0), 32'(e[0]));
        check({tag, ".q7"}, 32'(Q7), 32'(e[W-1]));
        check({tag, ".io_oe"}, 32'(IO_oe), 32'(model_oe()));
    endtask

    task automatic tick(input string tag);
        int nxt;
        nxt = model_next(m);
        @(posedge Clk);
        m = nxt;
        #1;
        check_all(tag);
    endtask

    initial begin
        probe = 1'bz;
        fourstate = $isunknown(probe);
        zv = fourstate ? 1'bz : 1'b1;

        MR_bar = 1'b1; S = 2'b00; OE1_bar = 1'b1; OE2_bar = 1'b1;
        DS0 = 1'b0; DS7 = 1'b0; IO_in = '0;
        #1;
        check_all("power_up");

        // Reset beats a simultaneous load.
        MR_bar = 1'b0; S = 2'b11; IO_in = 8'hA5;
        tick("reset_over_load");

        // Load 0x81, then shift right with DS0=0 until empty.
        MR_bar = 1'b1; S = 2'b11; IO_in = 8'h81;
        tick("load_81");
        S = 2'b01; DS0 = 1'b0;
        for (int i = 0; i < 8; i++) tick($sformatf("shr_%0d", i));

        // Load 0x01, shift left filling with ones.
        S = 2'b11; IO_in = 8'h01;
        tick("load_01");
        S = 2'b10; DS7 = 1'b1;
        for (int i = 0; i < 3; i++) tick($sformatf("shl_%0d", i));

        // Hold keeps contents; bus enable decode.
        S = 2'b00; OE1_bar = 1'b0; OE2_bar = 1'b0;
        tick("hold");
        check("oe_hold", 32'(IO_oe), 32'd1);
        S = 2'b11;
        #1;
        check("oe_load_forced_off", 32'(IO_oe), 32'd0);
        S = 2'b00; OE2_bar = zv;
        #1;
        check("oe2_floating", 32'(IO_oe), 32'd0);
        OE1_bar = 1'b1; OE2_bar = 1'b0;
        #1;
        check("oe1_high", 32'(IO_oe), 32'd0);

        // Floating MR_bar / S1 / DS7 read as 1: shift left, not reset.
        MR_bar = 1'b0; S = 2'b00;
        tick("clear_before_float");
        MR_bar = zv; S = {zv, 1'b0}; DS7 = zv;
        tick("float_shl");
        check("float_shl_value", 32'(IO_out), 32'h80);

        // Reset in the middle of a shift, then resume.
        MR_bar = 1'b1; DS7 = 1'b0; S = 2'b11; IO_in = 8'h3C;
        tick("load_3c");
        S = 2'b01; DS0 = 1'b1;
        tick("shr_run_0");
        tick("shr_run_1");
        MR_bar = 1'b0;
        tick("mid_shift_reset");
        check("mid_shift_reset_value", 32'(IO_out), 32'h00);
        MR_bar = 1'b1;
        tick("resume_shr");
        check("resume_shr_value", 32'(IO_out), 32'h01);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            MR_bar  = ($urandom_range(0, 9) != 0);
            S       = 2'($urandom);
            OE1_bar = 1'($urandom);
            OE2_bar = 1'($urandom);
            DS0     = 1'($urandom);
            DS7     = 1'($urandom);
            IO_in   = W'($urandom);
            tick($sformatf("rand_%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ttl_74323.md
TTL_74323 -- requirements
Module: ttl_74323

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (WIDTH >= 2).
REQ-002 SHALL have parameter DELAY_RISE, default 0, output 0->1 delay in time units.
REQ-003 SHALL have parameter DELAY_FALL, default 0, output 1->0 delay in time units.
REQ-004 SHALL have port Clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port MR_bar  input  1  master reset, synchronous, active-low.
REQ-006 SHALL have port S  input  2  mode select {S1,S0}.
REQ-007 SHALL have port OE1_bar  input  1  output enable 1, active-low.
REQ-008 SHALL have port OE2_bar  input  1  output enable 2, active-low.
REQ-009 SHALL have port DS0  input  1  serial in for shift-right (enters bit 0).
REQ-010 SHALL have port DS7  input  1  serial in for shift-left (enters bit WIDTH-1).
REQ-011 SHALL have port IO_in  input  WIDTH  parallel bus value seen by chip.
REQ-012 SHALL have port IO_out  output  WIDTH  register contents presented to bus.
REQ-013 SHALL have port IO_oe  output  1  high when IO_out drives bus; bus otherwise Z.
REQ-014 SHALL have port Q0  output  1  register bit 0, always driven.
REQ-015 SHALL have port Q7  output  1  register bit WIDTH-1, always driven.

Function
REQ-016 SHALL resolve every input bit that is Z or X to 1 (floating TTL input) before any decode.
REQ-017 SHALL, on rising Clk with MR_bar=0, load register with 0 regardless of S.
REQ-018 SHALL, on rising Clk with MR_bar=1, act per S: 00 hold; 01 shift right (Q[i]<=Q[i-1], Q[0]<=DS0); 10 shift left (Q[i]<=Q[i+1], Q[WIDTH-1]<=DS7); 11 parallel load Q<=IO_in.
REQ-019 SHALL apply a state change one Clk edge after inputs are sampled; latency 1 cycle, no pipelining.
REQ-020 SHALL drive IO_oe=1 only when OE1_bar=0, OE2_bar=0 and S!=11; else 0.
REQ-021 SHALL force IO_oe=0 combinationally in load mode so IO_in is never self-driven.
REQ-022 SHALL drive IO_out = register at all times, independent of IO_oe.
REQ-023 SHALL keep Q0/Q7 valid in every mode, including load and output-disabled.
REQ-024 SHALL apply DELAY_RISE/DELAY_FALL to IO_out, IO_oe, Q0, Q7; zero delay is pure combinational/register output.
REQ-025 SHALL, in shift modes, discard the bit shifted out of the far end (no wrap-around).
REQ-026 SHALL give MR_bar priority over any simultaneous S value, including load.

Reset
REQ-027 SHALL implement reset only as synchronous MR_bar=0 sampled at rising Clk; no asynchronous path.
REQ-028 SHALL yield after reset: register=0, IO_out=0, Q0=0, Q7=0; IO_oe per REQ-020.
REQ-029 SHALL initialise register to 0 at time zero so outputs are X-free before the first reset.
REQ-030 SHALL abort any shift/load in progress when MR_bar=0 at an edge; the next edge with MR_bar=1 resumes per S.

Structure
REQ-031 SHALL take mode encodings (HOLD=00, SHR=01, SHL=10, LOAD=11) from the shared ttl package/include, not local literals.
REQ-032 SHALL use one sub-module, ttl_input_resolve (Z/X->1 per bit, parameter WIDTH), on every input.
REQ-033 SHALL be lint-clean in Verilator with no inout ports.

Verification
REQ-034 SHALL cover: MR_bar=0, S=11, IO_in=8'hA5, one edge -> register=8'h00, Q0=0, Q7=0.
REQ-035 SHALL cover: load 8'h81 (S=11), then S=01, DS0=0, 8 edges -> 8'h02,8'h04,...,8'h00; Q7=1 after edge 6, 0 after 7.
REQ-036 SHALL cover: register 8'h01, S=10, DS7=1, 3 edges -> 8'h80, 8'hC0, 8'hE0.
REQ-037 SHALL cover: OE1_bar=0, OE2_bar=0, S=00 -> IO_oe=1; S=11 -> IO_oe=0 same delta; OE2_bar=Z -> IO_oe=0.
REQ-038 SHALL cover: MR_bar=Z, S=2'bZ0, DS7=Z, register 8'h00, one edge -> treated as shift-left, not reset -> 8'h80.
REQ-039 SHALL cover: reset mid-shift (S=01 running, MR_bar=0 one edge) -> 8'h00, then shifting resumes with DS0=1 -> 8'h01.
